front_panel_switch_conditioner: RTL and testbench

//  Parametrised successor to the Altair front-panel switch and LED mapping stage.

---
 rtl/front_panel_switch_conditioner.sv | 114 +++++++++++
 tb/tb_front_panel_switch_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_switch_conditioner.sv
// Front-panel switch conditioner: per-switch debounce of two- and three-position
// switch codes, action pulses for three-position switches, power-blanked LED register.
module front_panel_switch_conditioner #(
    parameter int N2      = 19,
    parameter int N3      = 4,
    parameter int DEB_CYC = 16,
    parameter int LED_W   = 36,
    parameter int PWR_IDX = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2*N2-1:0]   sw2_code,
    input  logic [2*N3-1:0]   sw3_code,
    input  logic [LED_W-1:0]  led_in,
    output logic [N2-1:0]     sw2_state,
    output logic [N3-1:0]     sw3_up,
    output logic [N3-1:0]     sw3_down,
    output logic [N3-1:0]     sw3_up_p,
    output logic [N3-1:0]     sw3_down_p,
    output logic              power_on,
    output logic [LED_W-1:0]  leds
);

    localparam int NS = N2 + N3;
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] DEB = CW'(DEB_CYC);

    logic [2*NS-1:0] raw;
    logic [NS-1:0]   accept;

    assign raw = {sw3_code, sw2_code};

    // One candidate/counter pair per switch; accept fires on every edge where the
    // updated count equals DEB_CYC, so a saturated stable input re-accepts harmlessly.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_deb
            logic [1:0]    cand_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic [1:0]    code;

            assign code = raw[2*gi +: 2];

            always_comb begin
                cnt_next = cnt_reg;
                if (code != cand_reg) begin
                    cnt_next = CW'(1);
                end else if (cnt_reg < DEB) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            assign accept[gi] = (cnt_next == DEB);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cand_reg <= 2'd0;
                    cnt_reg  <= '0;
                end else begin
                    cand_reg <= code;
                    cnt_reg  <= cnt_next;
                end
            end
        end
    endgenerate

    logic [N2-1:0] sw2_next;
    logic [N3-1:0] up_next;
    logic [N3-1:0] down_next;
    logic [N3-1:0] up_p_next;
    logic [N3-1:0] down_p_next;

    // Invalid codes complete debounce but leave the accepted level untouched.
    always_comb begin
        sw2_next  = sw2_state;
        up_next   = sw3_up;
        down_next = sw3_down;
        for (int i = 0; i < N2; i++) begin
            if (accept[i] && !raw[2*i+1]) begin
                sw2_next[i] = raw[2*i];
            end
        end
        for (int j = 0; j < N3; j++) begin
            if (accept[N2+j] && (raw[2*(N2+j) +: 2] != 2'd3)) begin
                up_next[j]   = (raw[2*(N2+j) +: 2] == 2'd2);
                down_next[j] = (raw[2*(N2+j) +: 2] == 2'd1);
            end
        end
        up_p_next   = power_on ? (up_next & ~sw3_up)     : '0;
        down_p_next = power_on ? (down_next & ~sw3_down) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw2_state  <= '0;
            sw3_up     <= '0;
            sw3_down   <= '0;
            sw3_up_p   <= '0;
            sw3_down_p <= '0;
            leds       <= '0;
        end else begin
            sw2_state  <= sw2_next;
            sw3_up     <= up_next;
            sw3_down   <= down_next;
            sw3_up_p   <= up_p_next;
            sw3_down_p <= down_p_next;
            leds       <= power_on ? led_in : '0;
        end
    end

    assign power_on = sw2_state[PWR_IDX];

endmodule

// File: tb/tb_front_panel_switch_conditioner.sv
// Bench for front_panel_switch_conditioner: DEB_CYC=4 and DEB_CYC=1 instances on shared
// stimulus, scoreboarded against a behavioural run-length model plus directed spot checks.
module tb_front_panel_switch_conditioner;

    localparam int N2 = 19;
    localparam int N3 = 4;
    localparam int NS = N2 + N3;
    localparam int LW = 36;

    typedef struct packed {
        logic [N2-1:0] sw2;
        logic [N3-1:0] up;
        logic [N3-1:0] dn;
        logic [N3-1:0] upp;
        logic [N3-1:0] dnp;
        logic          pwr;
        logic [LW-1:0] leds;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic [2*N2-1:0] sw2;
    logic [2*N3-1:0] sw3;
    logic [LW-1:0]   led_in;

    logic [N2-1:0] a_sw2, b_sw2;
    logic [N3-1:0] a_up, a_dn, a_upp, a_dnp, b_up, b_dn, b_upp, b_dnp;
    logic          a_pwr, b_pwr;
    logic [LW-1:0] a_leds, b_leds;

    front_panel_switch_conditioner #(.N2(N2), .N3(N3), .DEB_CYC(4), .LED_W(LW), .PWR_IDX(16)) u4 (
        .clk(clk), .reset_n(reset_n), .sw2_code(sw2), .sw3_code(sw3), .led_in(led_in),
        .sw2_state(a_sw2), .sw3_up(a_up), .sw3_down(a_dn), .sw3_up_p(a_upp),
        .sw3_down_p(a_dnp), .power_on(a_pwr), .leds(a_leds));

    front_panel_switch_conditioner #(.N2(N2), .N3(N3), .DEB_CYC(1), .LED_W(LW), .PWR_IDX(16)) u1 (
        .clk(clk), .reset_n(reset_n), .sw2_code(sw2), .sw3_code(sw3), .led_in(led_in),
        .sw2_state(b_sw2), .sw3_up(b_up), .sw3_down(b_dn), .sw3_up_p(b_upp),
        .sw3_down_p(b_dnp), .power_on(b_pwr), .leds(b_leds));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index 0 = DEB_CYC 4, index 1 = DEB_CYC 1
    int         m_run [2][NS];
    logic [1:0] m_last[2][NS];
    logic [1:0] m_acc [2][NS];
    logic [3:0] m_upp [2];
    logic [3:0] m_dnp [2];
    logic [LW-1:0] m_leds[2];
    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) begin
                m_run[k][s]  = 0;
                m_last[k][s] = 2'd0;
                m_acc[k][s]  = 2'd0;
            end
            m_upp[k]  = '0;
            m_dnp[k]  = '0;
            m_leds[k] = '0;
        end
    endfunction

    function automatic void model_step(input int k, input int deb);
        logic [1:0] nacc[NS];
        logic [1:0] in;
        logic       pwr_old;
        pwr_old = m_acc[k][16][0];
        for (int s = 0; s < NS; s++) begin
            in = (s < N2) ? sw2[2*s +: 2] : sw3[2*(s-N2) +: 2];
            if (m_run[k][s] > 0 && in == m_last[k][s]) m_run[k][s] = m_run[k][s] + 1;
            else m_run[k][s] = 1;
            if (m_run[k][s] > 100) m_run[k][s] = 100;
            m_last[k][s] = in;
            nacc[s] = m_acc[k][s];
            if (m_run[k][s] >= deb) begin
                if ((s < N2 && in < 2'd2) || (s >= N2 && in != 2'd3)) nacc[s] = in;
            end
        end
        for (int j = 0; j < N3; j++) begin
            m_upp[k][j] = pwr_old && nacc[N2+j] == 2'd2 && m_acc[k][N2+j] != 2'd2;
            m_dnp[k][j] = pwr_old && nacc[N2+j] == 2'd1 && m_acc[k][N2+j] != 2'd1;
        end
        m_leds[k] = pwr_old ? led_in : '0;
        for (int s = 0; s < NS; s++) m_acc[k][s] = nacc[s];
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t e;
        for (int i = 0; i < N2; i++) e.sw2[i] = m_acc[k][i][0];
        for (int j = 0; j < N3; j++) begin
            e.up[j] = (m_acc[k][N2+j] == 2'd2);
            e.dn[j] = (m_acc[k][N2+j] == 2'd1);
        end
        e.upp  = m_upp[k];
        e.dnp  = m_dnp[k];
        e.pwr  = m_acc[k][16][0];
        e.leds = m_leds[k];
        return e;
    endfunction

    function automatic exp_t obs4();
        return '{sw2: a_sw2, up: a_up, dn: a_dn, upp: a_upp, dnp: a_dnp, pwr: a_pwr, leds: a_leds};
    endfunction

    function automatic exp_t obs1();
        return '{sw2: b_sw2, up: b_up, dn: b_dn, upp: b_upp, dnp: b_dnp, pwr: b_pwr, leds: b_leds};
    endfunction

    // inputs are set before the call; one edge, then both queues are drained
    task automatic cyc(input string tag);
        exp_t e4, e1;
        model_step(0, 4);
        model_step(1, 1);
        q4.push_back(model_out(0));
        q1.push_back(model_out(1));
        @(posedge clk);
        #1;
        e4 = q4.pop_front();
        e1 = q1.pop_front();
        chk({tag, "_deb4"}, 128'(obs4()), 128'(e4));
        chk({tag, "_deb1"}, 128'(obs1()), 128'(e1));
    endtask

    task automatic cycn(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_zero_deb4"}, 128'(obs4()), 128'(0));
        chk({tag, "_zero_deb1"}, 128'(obs1()), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        sw2 = '0;
        sw3 = '0;
        led_in = '0;
        reset_n = 1'b1;
        #2;
        do_reset("reset");
        cycn("idle", 2);

        // short glitch rejected, full run accepted
        sw2[1:0] = 2'd1; cycn("t1_glitch", 3);
        sw2[1:0] = 2'd0; cycn("t1_back", 2);
        chk("t1_glitch_rejected", 128'(a_sw2[0]), 128'(0));
        sw2[1:0] = 2'd1; cycn("t1_hold", 3);
        chk("t1_not_yet", 128'(a_sw2[0]), 128'(0));
        cyc("t1_edge4");
        chk("t1_accept_edge4", 128'(a_sw2[0]), 128'(1));

        // invalid codes hold
        sw2[1:0] = 2'd3; cycn("t2_invalid2", 10);
        chk("t2_hold_up", 128'(a_sw2[0]), 128'(1));
        sw3[1:0] = 2'd2; cycn("t2_sw3_up_unpowered", 6);
        sw3[1:0] = 2'd3; sw3[3:2] = 2'd3; cycn("t2_invalid3", 10);
        chk("t2_sw3_hold_up", 128'({a_up[1:0], a_dn[1:0]}), 128'(4'b0100));
        sw3[3:0] = 4'd0; cycn("t2_middle", 5);

        // power off: blanked LEDs, no pulses; then power on
        led_in = 36'hF_0000_FFFF;
        cycn("t4_off", 2);
        chk("t4_leds_blank", 128'(a_leds), 128'(0));
        sw3[5:4] = 2'd1; cycn("t4_act_off", 6);
        chk("t4_level_tracks", 128'(a_dn[2]), 128'(1));
        sw2[33:32] = 2'd1; cycn("t4_pwr", 4);
        chk("t4_power_on", 128'(a_pwr), 128'(1));
        chk("t4_leds_lag", 128'(a_leds), 128'(0));
        cyc("t4_leds");
        chk("t4_leds_on", 128'(a_leds), 128'(36'hF_0000_FFFF));

        // powered actuation: one pulse each, up->down direct
        cnt = 0;
        sw3[1:0] = 2'd2;
        for (int i = 0; i < 20; i++) begin
            cyc("t3_up");
            if (a_upp[0]) cnt++;
            if (i == 3) chk("t3_pulse_edge4", 128'({a_up[0], a_upp[0]}), 128'(2'b11));
        end
        chk("t3_up_pulse_count", 128'(cnt), 128'(1));
        cnt = 0;
        sw3[1:0] = 2'd1;
        for (int i = 0; i < 8; i++) begin
            cyc("t3_down");
            if (a_dnp[0]) cnt++;
            if (a_upp[0]) cnt += 10;
        end
        chk("t3_down_pulse_count", 128'(cnt), 128'(1));
        chk("t3_levels", 128'({a_up[0], a_dn[0]}), 128'(2'b01));

        // reset mid-debounce
        sw2[3:2] = 2'd1; cycn("t5_partial", 2);
        do_reset("t5_reset");
        cycn("t5_after", 3);
        chk("t5_needs_full", 128'(a_sw2[1]), 128'(0));
        cyc("t5_edge4");
        chk("t5_accept", 128'({a_sw2[1], a_pwr}), 128'(2'b11));

        // everything toggles every cycle
        for (int i = 0; i < 12; i++) begin
            sw2 = (i % 2 == 0) ? {N2{2'b01}} : '0;
            sw3 = (i % 2 == 0) ? {N3{2'b10}} : {N3{2'b01}};
            led_in = {4'($urandom), $urandom};
            cyc("t6_toggle");
            chk("t6_sw2_follow", 128'(b_sw2), (i % 2 == 0) ? 128'({N2{1'b1}}) : 128'(0));
            chk("t6_sw3_follow", 128'({b_up, b_dn}), (i % 2 == 0) ? 128'(8'hF0) : 128'(8'h0F));
        end

        // sparse random changes, many switches at once
        for (int i = 0; i < 150; i++) begin
            for (int s = 0; s < N2; s++)
                if ($urandom_range(7) == 0) sw2[2*s +: 2] = 2'($urandom);
            for (int s = 0; s < N3; s++)
                if ($urandom_range(5) == 0) sw3[2*s +: 2] = 2'($urandom);
            if ($urandom_range(3) == 0) sw2[33:32] = 2'd1;
            led_in = {4'($urandom), $urandom};
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
